// File: rtl/integ_dump.sv
// integ_dump: integrate-and-dump decimator. Sums 2^LOG2_N accepted samples,
// then emits their floor (or round-half-up) average with a one-cycle strobe
// that serves as the clock enable of the downstream holding register.
module integ_dump #(
    parameter int W_IN   = 16,
    parameter int LOG2_N = 2,
    parameter int ROUND  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic signed [W_IN-1:0]   din,
    output logic signed [W_IN-1:0]   dout,
    output logic                     dout_valid,
    output logic        [LOG2_N-1:0] cnt
);

    // One guard bit beyond the N-fold growth absorbs the rounding offset.
    localparam int AW = W_IN + LOG2_N + 1;
    localparam logic signed [AW-1:0] RND_ADD = AW'(ROUND != 0 ? (1 << (LOG2_N - 1)) : 0);

    logic signed [AW-1:0]     acc_q, acc_d;
    logic        [LOG2_N-1:0] cnt_q, cnt_d;
    logic signed [W_IN-1:0]   dout_q, dout_d;
    logic                     dout_valid_q, dout_valid_d;

    logic signed [AW-1:0]     din_x;
    logic signed [AW-1:0]     sum;
    logic                     last;

    assign din_x = {{(LOG2_N + 1){din[W_IN-1]}}, din};
    assign sum   = acc_q + din_x + RND_ADD;
    assign last  = &cnt_q;

    // Next-state: clr aborts the block, accepted samples accumulate or dump.
    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_valid) begin
            if (last) begin
                dout_d       = W_IN'(sum >>> LOG2_N);
                dout_valid_d = 1'b1;
                acc_d        = '0;
                cnt_d        = '0;
            end else begin
                acc_d = acc_q + din_x;
                cnt_d = cnt_q + LOG2_N'(1);
            end
        end
    end

    // State registers; synchronous reset overrides everything, including a dump.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign cnt        = cnt_q;

endmodule

// File: tb/tb_integ_dump.sv
// Testbench for integ_dump: a truncating and a rounding instance share one
// input stream; a block-level model predicts every output on every cycle.
module tb_integ_dump;

    localparam int W_IN   = 16;
    localparam int LOG2_N = 2;
    localparam int N      = 1 << LOG2_N;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     clr = 1'b0;
    logic                     in_valid = 1'b0;
    logic signed [W_IN-1:0]   din = '0;

    logic signed [W_IN-1:0]   dout0, dout1;
    logic                     dv0, dv1;
    logic        [LOG2_N-1:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    integ_dump #(.W_IN(W_IN), .LOG2_N(LOG2_N), .ROUND(0)) dut_trunc (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .din(din),
        .dout(dout0), .dout_valid(dv0), .cnt(cnt0)
    );

    integ_dump #(.W_IN(W_IN), .LOG2_N(LOG2_N), .ROUND(1)) dut_round (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .din(din),
        .dout(dout1), .dout_valid(dv1), .cnt(cnt1)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int blk[$];
    int m_dout0 = 0, m_dout1 = 0, m_cnt = 0;
    bit m_valid = 1'b0;
    bit model_live = 1'b0;
    bit prev_valid = 1'b0;

    function automatic int floor_div(input int a, input int n);
        int q;
        q = a / n;
        if ((a % n) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    always @(posedge clk) begin
        int s;
        if (rst) begin
            blk.delete();
            m_dout0 = 0;
            m_dout1 = 0;
            m_valid = 1'b0;
        end else if (clr) begin
            blk.delete();
            m_valid = 1'b0;
        end else if (in_valid) begin
            blk.push_back(int'(din));
            if (blk.size() == N) begin
                s = 0;
                foreach (blk[i]) s += blk[i];
                m_dout0 = floor_div(s, N);
                m_dout1 = floor_div(s + N / 2, N);
                m_valid = 1'b1;
                blk.delete();
            end else begin
                m_valid = 1'b0;
            end
        end else begin
            m_valid = 1'b0;
        end
        m_cnt = blk.size();
        model_live = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (model_live) begin
            chk("dout_trunc", int'(dout0), m_dout0);
            chk("dout_round", int'(dout1), m_dout1);
            chk("valid_trunc", int'(dv0), int'(m_valid));
            chk("valid_round", int'(dv1), int'(m_valid));
            chk("cnt_trunc", int'(cnt0), m_cnt);
            chk("cnt_round", int'(cnt1), m_cnt);
            if (dv0 && prev_valid) chk("no_back_to_back", 1, 0);
            prev_valid = dv0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input int d, input bit c, input bit r);
        in_valid = v;
        din      = W_IN'(d);
        clr      = c;
        rst      = r;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr      = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic block4(input int a, input int b, input int c, input int d);
        step(1, a, 0, 0);
        step(1, b, 0, 0);
        step(1, c, 0, 0);
        step(1, d, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("reset_dout", int'(dout0), 0);
        chk("reset_valid", int'(dv0), 0);
        chk("reset_cnt", int'(cnt0), 0);

        // 1,2,3,4 continuous: cnt 1,2,3,0 and averages 2 / 3
        step(1, 1, 0, 0); chk("cnt_seq1", int'(cnt0), 1);
        step(1, 2, 0, 0); chk("cnt_seq2", int'(cnt0), 2);
        step(1, 3, 0, 0); chk("cnt_seq3", int'(cnt0), 3);
        chk("no_strobe_early", int'(dv0), 0);
        step(1, 4, 0, 0); chk("cnt_seq0", int'(cnt0), 0);
        chk("lit_1234_valid", int'(dv0), 1);
        chk("lit_1234_trunc", int'(dout0), 2);
        chk("lit_1234_round", int'(dout1), 3);
        step(0, 0, 0, 0);
        chk("strobe_one_cycle", int'(dv0), 0);

        block4(-1, -1, -1, -2);
        chk("lit_neg_trunc", int'(dout0), -2);
        chk("lit_neg_round", int'(dout1), -1);

        block4(32767, 32767, 32767, 32767);
        chk("lit_fs_pos_trunc", int'(dout0), 32767);
        chk("lit_fs_pos_round", int'(dout1), 32767);

        block4(-32768, -32768, -32768, -32768);
        chk("lit_fs_neg_trunc", int'(dout0), -32768);
        chk("lit_fs_neg_round", int'(dout1), -32768);

        // gapped input
        for (int i = 0; i < 4; i++) begin
            step(1, 5, 0, 0);
            if (i < 3) for (int g = 0; g < 3; g++) step(0, 0, 0, 0);
        end
        chk("lit_gap_valid", int'(dv0), 1);
        chk("lit_gap_dout", int'(dout0), 5);

        // abort with clr
        step(1, 100, 0, 0); step(1, 100, 0, 0); step(1, 100, 0, 0);
        step(1, 100, 1, 0);
        chk("lit_clr_cnt", int'(cnt0), 0);
        chk("lit_clr_dout_held", int'(dout0), 5);
        block4(8, 8, 8, 8);
        chk("lit_clr_dout", int'(dout0), 8);

        // abort with rst
        step(1, 100, 0, 0); step(1, 100, 0, 0); step(1, 100, 0, 0);
        step(1, 100, 0, 1);
        chk("lit_rst_dout_zero", int'(dout0), 0);
        step(1, 8, 0, 0); step(1, 8, 0, 0); step(1, 8, 0, 0);
        chk("lit_rst_dout_before", int'(dout0), 0);
        step(1, 8, 0, 0);
        chk("lit_rst_dout", int'(dout0), 8);

        // reset during a dump cycle
        step(1, 9, 0, 0); step(1, 9, 0, 0); step(1, 9, 0, 0);
        step(1, 9, 0, 1);
        chk("lit_rst_dump_valid", int'(dv0), 0);
        chk("lit_rst_dump_dout", int'(dout0), 0);

        // long random run
        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 65535)) - 32768, 0, 0);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
